// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter feeding a synchronous FIFO
//
// Purpose:
//   Arbitrates NREQ valid/ready requesters onto a single FIFO write port.
//   A two-state FSM (IDLE/GRANT) picks the first valid requester searching
//   upward from a round-robin pointer. It then forwards that requester's
//   beats to the FIFO while the FIFO is not full.
//
// Optional feature:
//   FIFO_ARB_BURST_EN - when defined, a grant is held across beats. It is
//   released on the beat carrying req_last or on the BURST_MAX-th beat.
//   When undefined, every transferred beat releases the grant and req_last
//   is ignored.
//
// Ports:
//   wclk       in   write-side clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]        per-requester data valid
//   req_last   in   [NREQ]        per-requester last beat of burst
//   req_data   in   [NREQ*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//   req_ready  out  [NREQ]        per-requester accept
//   wfull      in   downstream FIFO full flag
//   winc       out  FIFO write enable
//   wdata      out  [WIDTH]       FIFO write data
//   gnt_id     out  [clog2(NREQ)] index of the current grantee
//   busy       out  high while in GRANT

module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int BURST_MAX = 4,
    localparam int GW       = $clog2(NREQ),
    localparam int BCW      = $clog2(BURST_MAX) + 1
) (
    input  logic                  wclk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [WIDTH-1:0]      wdata,
    output logic [GW-1:0]         gnt_id,
    output logic                  busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gnt_id_q, gnt_id_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;

    // Rotate the valid vector so that bit 0 corresponds to rr_ptr. The
    // round-robin search then becomes a fixed-priority search from bit 0.
    logic [2*NREQ-1:0] valid_dbl;
    logic [NREQ-1:0]   valid_rot;
    logic              any_valid;
    logic [GW-1:0]     pick_off;
    logic [GW:0]       pick_sum;
    logic [GW-1:0]     pick;

    assign valid_dbl = {req_valid, req_valid};
    assign valid_rot = NREQ'(valid_dbl >> rr_ptr_q);

    always_comb begin
        any_valid = 1'b0;
        pick_off  = '0;
        // Walk downward so the lowest offset from rr_ptr wins.
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (valid_rot[j]) begin
                any_valid = 1'b1;
                pick_off  = GW'(j);
            end
        end
        // Map the rotated offset back to an absolute index, modulo NREQ.
        pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
        if (pick_sum >= (GW+1)'(NREQ)) begin
            pick_sum = pick_sum - (GW+1)'(NREQ);
        end
        pick = pick_sum[GW-1:0];
    end

    logic gnt_valid;
    logic release_beat;
    logic [GW-1:0] rr_next;

    assign gnt_valid = req_valid[gnt_id_q];
    assign rr_next   = (gnt_id_q == GW'(NREQ - 1)) ? '0 : gnt_id_q + 1'b1;

`ifdef FIFO_ARB_BURST_EN
    logic gnt_last;
    assign gnt_last     = req_last[gnt_id_q];
    // beat_cnt_q holds the beats already moved in this grant. The current
    // beat is therefore the BURST_MAX-th beat when beat_cnt_q is BURST_MAX-1.
    assign release_beat = gnt_last || (beat_cnt_q == BCW'(BURST_MAX - 1));
`else
    logic unused_last;
    assign unused_last  = ^req_last;
    assign release_beat = 1'b1;
`endif

    // Datapath outputs depend only on the registered state and the live
    // inputs. This lets wfull stall a beat in the same cycle it rises.
    always_comb begin
        req_ready = '0;
        winc      = 1'b0;
        wdata     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id_q == GW'(i)) begin
                wdata = req_data[i*WIDTH +: WIDTH];
            end
        end
        if (state_q == GRANT) begin
            req_ready[gnt_id_q] = !wfull;
            winc                = gnt_valid && !wfull;
        end
    end

    assign gnt_id = gnt_id_q;
    assign busy   = (state_q == GRANT);

    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d    = GRANT;
                    gnt_id_d   = pick;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!gnt_valid) begin
                    // The grantee withdrew, so release without a transfer.
                    state_d    = IDLE;
                    rr_ptr_d   = rr_next;
                    beat_cnt_d = '0;
                end else if (!wfull) begin
                    if (release_beat) begin
                        state_d    = IDLE;
                        rr_ptr_d   = rr_next;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_id_q   <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 8, data width.
- NREQ, default 4, number of requesters (2..8).
- BURST_MAX, default 4, maximum beats per grant when bursts are enabled (1..16).

REQ-002 Ports SHALL be:
- wclk  input  1  write-side clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NREQ  per-requester data valid.
- req_last  input  NREQ  per-requester last beat of burst.
- req_data  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  per-requester accept.
- wfull  input  1  full flag of the downstream synchronous FIFO.
- winc  output  1  FIFO write enable.
- wdata  output  WIDTH  FIFO write data.
- gnt_id  output  clog2(NREQ)  index of the current grantee.
- busy  output  1  high while in GRANT.

Function
REQ-003 FSM SHALL have two states, IDLE and GRANT.
REQ-004 IDLE: if any req_valid is high, the block SHALL register gnt_id as the first valid index found searching upward from rr_ptr (modulo NREQ) and enter GRANT on the next edge; otherwise it stays in IDLE.
REQ-005 In IDLE, req_ready SHALL be all 0 and winc SHALL be 0.
REQ-006 GRANT outputs (combinational):
- req_ready[gnt_id] = !wfull; all other req_ready bits 0.
- winc = req_valid[gnt_id] & !wfull.
- wdata = req_data slice of gnt_id.
REQ-007 A beat SHALL transfer exactly in each GRANT cycle where winc=1; the FIFO SHALL see one write per beat.
REQ-008 wfull=1 in GRANT SHALL stall the transfer: winc=0, grant held, beat count unchanged. No data is lost or duplicated.
REQ-009 Arbitration latency SHALL be one cycle. With req_valid rising in IDLE cycle n, the earliest winc is cycle n+1.
REQ-010 The grant SHALL be released, returning to IDLE on the next edge, on whichever comes first:
- the release beat transfers (see REQ-017/018);
- req_valid[gnt_id] is low in a GRANT cycle; no transfer occurs in that cycle.
REQ-011 On every release, rr_ptr SHALL become (gnt_id+1) mod NREQ.
REQ-012 After a release there is one IDLE cycle before the next grant, so the maximum throughput is 1 beat per 2 cycles in single-beat mode.
REQ-013 beat_cnt (clog2(BURST_MAX)+1 bits) SHALL count beats within a grant and clear to 0 on release.
REQ-014 req_data/req_last of non-granted requesters SHALL be ignored.

Reset
REQ-015 rst_n low SHALL asynchronously force:
- state=IDLE, rr_ptr=0, beat_cnt=0, gnt_id=0, busy=0;
- winc=0, req_ready=0 immediately, including mid-burst; wdata is don't-care.
REQ-016 After rst_n deasserts, the first arbitration SHALL start searching from index 0.

Configuration
REQ-017 With FIFO_ARB_BURST_EN defined, the release beat SHALL be the transferred beat with req_last[gnt_id]=1 or the BURST_MAX-th transferred beat, whichever comes first; the grant is held between beats.
REQ-018 Without FIFO_ARB_BURST_EN, the release beat SHALL be every transferred beat, and req_last SHALL be ignored.

Verification
REQ-019 Single requester, macro off: req_valid=4'b0010, data 0xA5 -> gnt_id=1 next cycle; winc=1, wdata=0xA5 for one cycle; back to IDLE; rr_ptr=2.
REQ-020 Round robin, macro off: req_valid=4'b1111 held -> grant order 0,1,2,3,0; one write every 2 cycles.
REQ-021 Full stall: grant to req 2, then wfull=1 for 3 cycles -> winc=0 and req_ready=0 for 3 cycles; the data word is written once after wfull falls.
REQ-022 Burst, macro on, BURST_MAX=4: req 0 sends 6 beats with req_last on beat 6, req 1 valid -> beats 1-4 from req 0, then req 1 granted, then req 0 beats 5-6.
REQ-023 Burst with early req_last, macro on: req 3 sends 2 beats with req_last on beat 2 -> release after 2 beats; rr_ptr=0.
REQ-024 Reset mid-burst: rst_n low during beat 2 of a 4-beat burst -> winc and req_ready go 0 immediately; after release, req_valid=4'b0100 is granted to 2 with searching from 0.
